pipe_rca_adder: RTL

PIPE_RCA_ADDER -- requirements
Module: pipe_rca_adder

---
 rtl/pipe_add_pkg.sv | 24 ++
 rtl/rca_slice.sv | 30 +++
 rtl/pipe_rca_adder.sv | 91 +++++++++
 3 files changed

// File: rtl/pipe_add_pkg.sv
// Shared constants, the per-stage payload carried down the adder pipeline,
// and the full-adder cell every ripple slice is built from.
package pipe_add_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_STAGES = 4;
  // Payload vectors are sized for the widest supported adder; narrower
  // instances zero-extend and the unused upper bits are constant zero.
  localparam int MAX_WIDTH  = 64;

  typedef struct packed {
    logic                 valid;
    logic [MAX_WIDTH-1:0] sum;        // completed low chunks, filled in stage by stage
    logic [MAX_WIDTH-1:0] a;          // operand A, chunks still pending above the sum
    logic [MAX_WIDTH-1:0] b;          // operand B, already inverted for subtraction
    logic                 carry;      // carry out of the last chunk added
    logic                 sign_carry; // carry into the MSB of the last chunk added
  } stage_t;

  function automatic logic [1:0] fa(input logic x, input logic y, input logic ci);
    return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
  endfunction

endpackage

// File: rtl/rca_slice.sv
// CHUNK-bit combinational ripple-carry adder built from the shared FA cell;
// also exports the carry into its MSB for overflow detection.
module rca_slice
  import pipe_add_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      {c[i+1], sum[i]} = fa(a[i], b[i], c[i]);
    end
  end

  assign cout  = c[CHUNK];
  assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/pipe_rca_adder.sv
// Pipelined ripple-carry adder/subtractor: one CHUNK-bit slice per stage,
// with operands and partial sums skewed down a register chain.
module pipe_rca_adder
  import pipe_add_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  if ((WIDTH % STAGES) != 0 || WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_width_check
    $error("pipe_rca_adder: WIDTH must be >= 2, <= MAX_WIDTH and a multiple of STAGES");
  end

  // Handshake: a beat moves on an interface when valid and ready are both
  // high at a rising edge; out_valid/result never change while held off,
  // and in_ready drops combinationally whenever the output is stalled.
  stage_t stage_q [STAGES+1];
  stage_t stage_d [STAGES+1];

  logic                          stall;
  logic [WIDTH-1:0]              b_eff;
  logic [STAGES-1:0][CHUNK-1:0]  slice_sum;
  logic [STAGES-1:0]             slice_co;
  logic [STAGES-1:0]             slice_cm;

  assign stall    = stage_q[STAGES].valid & ~out_ready;
  assign in_ready = ~stall;
  assign b_eff    = sub ? ~b : b;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    rca_slice #(.CHUNK(CHUNK)) u_slice (
      .a     (stage_q[k].a[k*CHUNK +: CHUNK]),
      .b     (stage_q[k].b[k*CHUNK +: CHUNK]),
      .cin   (stage_q[k].carry),
      .sum   (slice_sum[k]),
      .cout  (slice_co[k]),
      .c_msb (slice_cm[k])
    );
  end

  always_comb begin
    for (int k = 0; k <= STAGES; k++) begin
      stage_d[k] = '0;
    end
    // Rank 0 captures the operands; subtraction is A + ~B + 1.
    stage_d[0].valid = in_valid;
    stage_d[0].a     = MAX_WIDTH'(a);
    stage_d[0].b     = MAX_WIDTH'(b_eff);
    stage_d[0].carry = sub | cin;
    for (int k = 0; k < STAGES; k++) begin
      stage_d[k+1]                        = stage_q[k];
      stage_d[k+1].sum[k*CHUNK +: CHUNK]  = slice_sum[k];
      stage_d[k+1].carry                  = slice_co[k];
      stage_d[k+1].sign_carry             = slice_cm[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= STAGES; k++) begin
        stage_q[k] <= '0;
      end
    end else if (!stall) begin
      for (int k = 0; k <= STAGES; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign out_valid = stage_q[STAGES].valid;
  assign sum       = stage_q[STAGES].sum[WIDTH-1:0];
  assign cout      = stage_q[STAGES].carry;
  assign ovf       = stage_q[STAGES].sign_carry ^ stage_q[STAGES].carry;

endmodule
